// File: rtl/shift_register_param_if.sv
// Bundle of the shift register's control, data and status signals.
//   master : drives load/start/config/data_in/ser_in, reads data_out and status
//   slave  : the shift register itself
// Signals
//   i_load        parallel load strobe
//   i_data_in     parallel load value
//   i_start       begin a shift operation
//   i_dir         0 = right, 1 = left
//   i_mode        00 logical, 01 arithmetic, 10 rotate, 11 serial fill
//   i_shamt       number of bit positions to shift
//   i_ser_in      fill bit for serial mode
//   o_data_out    register contents
//   o_shifted_out last bit shifted or rotated out
//   o_busy        high while shifting
//   o_done        one-cycle completion pulse
interface shift_register_param_if #(
    parameter int WIDTH   = 16,
    parameter int SHAMT_W = 5
);
    logic               i_load;
    logic [WIDTH-1:0]   i_data_in;
    logic               i_start;
    logic               i_dir;
    logic [1:0]         i_mode;
    logic [SHAMT_W-1:0] i_shamt;
    logic               i_ser_in;
    logic [WIDTH-1:0]   o_data_out;
    logic               o_shifted_out;
    logic               o_busy;
    logic               o_done;

    modport master (
        output i_load, i_data_in, i_start, i_dir, i_mode, i_shamt, i_ser_in,
        input  o_data_out, o_shifted_out, o_busy, o_done
    );

    modport slave (
        input  i_load, i_data_in, i_start, i_dir, i_mode, i_shamt, i_ser_in,
        output o_data_out, o_shifted_out, o_busy, o_done
    );
endinterface

// File: rtl/shift_register_param.sv
// Multi-mode shift register: parallel load, then a programmable number of
// 1-bit shift steps (logical, arithmetic, rotate or serial fill) under a
// start/busy/done handshake.
// Ports
//   i_clk    rising-edge clock
//   i_rst_n  asynchronous active-low reset
//   bus      shift_register_param_if.slave (control, data and status)
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_IDLE  | waiting; accepts load (priority) or start
// ST_SHIFT | one shift step per clock, down-counter r_cnt tracks steps
// ST_DONE  | single-cycle completion pulse, then back to ST_IDLE
module shift_register_param #(
    parameter int WIDTH   = 16,
    parameter int SHAMT_W = 5
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    shift_register_param_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [1:0] MODE_LOG = 2'b00;
    localparam logic [1:0] MODE_ARI = 2'b01;
    localparam logic [1:0] MODE_ROT = 2'b10;

    localparam logic [SHAMT_W-1:0] CNT_ONE = {{(SHAMT_W-1){1'b0}}, 1'b1};

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH-1:0]   r_data;
    logic               r_shout;
    logic               r_dir;
    logic [1:0]         r_mode;
    logic [SHAMT_W-1:0] r_cnt;

    logic               w_accept;
    logic               w_last;
    logic               w_fill;
    logic [WIDTH-1:0]   w_step_data;
    logic               w_step_out;

    // load wins over start in the same cycle
    assign w_accept = bus.i_start & ~bus.i_load;
    assign w_last   = (r_cnt == CNT_ONE);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = (bus.i_shamt != '0) ? ST_SHIFT : ST_DONE;
                end
            end
            ST_SHIFT: begin
                if (w_last) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Fill bit entering the vacated end; arithmetic left behaves as logical.
    always_comb begin
        w_fill = 1'b0;
        case (r_mode)
            MODE_LOG: w_fill = 1'b0;
            MODE_ARI: w_fill = r_dir ? 1'b0 : r_data[WIDTH-1];
            MODE_ROT: w_fill = r_dir ? r_data[WIDTH-1] : r_data[0];
            default:  w_fill = bus.i_ser_in;
        endcase
    end

    always_comb begin
        w_step_data = r_data;
        w_step_out  = r_shout;
        if (r_dir) begin
            w_step_data = {r_data[WIDTH-2:0], w_fill};
            w_step_out  = r_data[WIDTH-1];
        end else begin
            w_step_data = {w_fill, r_data[WIDTH-1:1]};
            w_step_out  = r_data[0];
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
            r_data  <= '0;
            r_shout <= 1'b0;
            r_dir   <= 1'b0;
            r_mode  <= MODE_LOG;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                ST_IDLE: begin
                    if (bus.i_load) begin
                        r_data <= bus.i_data_in;
                    end else if (bus.i_start) begin
                        r_dir  <= bus.i_dir;
                        r_mode <= bus.i_mode;
                        r_cnt  <= bus.i_shamt;
                    end
                end
                ST_SHIFT: begin
                    r_data  <= w_step_data;
                    r_shout <= w_step_out;
                    r_cnt   <= r_cnt - CNT_ONE;
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.o_data_out    = r_data;
    assign bus.o_shifted_out = r_shout;
    assign bus.o_busy        = (r_state == ST_SHIFT);
    assign bus.o_done        = (r_state == ST_DONE);

endmodule

// File: tb/tb_shift_register_param.sv
// Directed bench for shift_register_param (WIDTH=16, SHAMT_W=5).
module tb_shift_register_param;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    shift_register_param_if #(.WIDTH(16), .SHAMT_W(5)) sr_if ();

    shift_register_param #(.WIDTH(16), .SHAMT_W(5)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (sr_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [15:0] val);
        sr_if.i_load    = 1'b1;
        sr_if.i_data_in = val;
        step();
        sr_if.i_load    = 1'b0;
        sr_if.i_data_in = 16'h0000;
    endtask

    // Start an operation and follow it to completion. The start edge counts
    // as clock 1, so done must appear after clock shamt+1 and busy must be
    // seen for exactly shamt cycles. With disturb set, load=FFFF and start
    // are driven during the first SHIFT cycle and must be ignored.
    task automatic do_op(input string tag, input logic dir, input logic [1:0] mode,
                         input logic [4:0] shamt, input logic ser,
                         input logic [15:0] exp_data, input logic exp_so,
                         input bit disturb);
        int edges;
        int busy_cnt;
        sr_if.i_start  = 1'b1;
        sr_if.i_dir    = dir;
        sr_if.i_mode   = mode;
        sr_if.i_shamt  = shamt;
        sr_if.i_ser_in = ser;
        step();
        sr_if.i_start = 1'b0;
        edges    = 1;
        busy_cnt = 0;
        while (!sr_if.o_done && edges < 100) begin
            if (sr_if.o_busy) busy_cnt++;
            if (disturb && edges == 1) begin
                sr_if.i_load    = 1'b1;
                sr_if.i_data_in = 16'hFFFF;
                sr_if.i_start   = 1'b1;
                sr_if.i_shamt   = 5'd0;
            end else begin
                sr_if.i_load    = 1'b0;
                sr_if.i_data_in = 16'h0000;
                sr_if.i_start   = 1'b0;
            end
            step();
            edges++;
        end
        sr_if.i_load  = 1'b0;
        sr_if.i_start = 1'b0;
        chk({tag, " latency"}, edges, shamt + 1);
        chk({tag, " busy_cycles"}, busy_cnt, shamt);
        chk({tag, " data"}, sr_if.o_data_out, exp_data);
        chk({tag, " shifted_out"}, sr_if.o_shifted_out, exp_so);
        // A start presented during DONE must not launch a new operation.
        sr_if.i_start = 1'b1;
        sr_if.i_shamt = 5'd3;
        step();
        sr_if.i_start = 1'b0;
        chk({tag, " idle_after_done"}, {sr_if.o_busy, sr_if.o_done}, 2'b00);
        chk({tag, " data_after_done"}, sr_if.o_data_out, exp_data);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n           = 1'b0;
        sr_if.i_load    = 1'b0;
        sr_if.i_data_in = 16'h0000;
        sr_if.i_start   = 1'b0;
        sr_if.i_dir     = 1'b0;
        sr_if.i_mode    = 2'b00;
        sr_if.i_shamt   = 5'd0;
        sr_if.i_ser_in  = 1'b0;
        step();
        step();
        chk("reset outputs", {sr_if.o_data_out, sr_if.o_shifted_out, sr_if.o_busy, sr_if.o_done}, 19'h0);
        rst_n = 1'b1;
        step();

        do_load(16'hB6A5);
        chk("load value", sr_if.o_data_out, 16'hB6A5);
        do_op("t1 log_r4", 1'b0, 2'b00, 5'd4, 1'b0, 16'h0B6A, 1'b0, 1'b0);

        do_load(16'h8001);
        do_op("t2 ari_r3", 1'b0, 2'b01, 5'd3, 1'b0, 16'hF000, 1'b0, 1'b0);
        do_load(16'h8001);
        do_op("t2 ari_r20", 1'b0, 2'b01, 5'd20, 1'b0, 16'hFFFF, 1'b1, 1'b0);

        do_load(16'h8001);
        do_op("t3 rot_l1", 1'b1, 2'b10, 5'd1, 1'b0, 16'h0003, 1'b1, 1'b0);
        do_load(16'h8001);
        do_op("t3 rot_r16", 1'b0, 2'b10, 5'd16, 1'b0, 16'h8001, 1'b1, 1'b0);
        do_op("t3 rot_l17", 1'b1, 2'b10, 5'd17, 1'b0, 16'h0003, 1'b1, 1'b0);

        do_load(16'hC001);
        do_op("ari_l1", 1'b1, 2'b01, 5'd1, 1'b0, 16'h8002, 1'b1, 1'b0);
        do_load(16'h00FF);
        do_op("log_l20 flush", 1'b1, 2'b00, 5'd20, 1'b0, 16'h0000, 1'b0, 1'b0);

        do_load(16'h0000);
        do_op("t4 ser_r4", 1'b0, 2'b11, 5'd4, 1'b1, 16'hF000, 1'b0, 1'b0);
        do_op("t4 ser_l2", 1'b1, 2'b11, 5'd2, 1'b0, 16'hC000, 1'b1, 1'b0);

        // shamt=0 and load both leave shifted_out (currently 1) untouched
        do_op("t5 shamt0", 1'b0, 2'b00, 5'd0, 1'b0, 16'hC000, 1'b1, 1'b0);
        do_load(16'hB6A5);
        chk("t5 load keeps shifted_out", sr_if.o_shifted_out, 1'b1);
        do_op("t5 disturbed", 1'b0, 2'b00, 5'd4, 1'b0, 16'h0B6A, 1'b0, 1'b1);

        // Reset in the middle of a shift
        do_load(16'hB6A5);
        sr_if.i_start = 1'b1;
        sr_if.i_dir   = 1'b0;
        sr_if.i_mode  = 2'b00;
        sr_if.i_shamt = 5'd4;
        step();
        sr_if.i_start = 1'b0;
        step();
        chk("t6 busy before reset", sr_if.o_busy, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("t6 async reset outputs", {sr_if.o_data_out, sr_if.o_shifted_out, sr_if.o_busy, sr_if.o_done}, 19'h0);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("t6 no done in reset", {sr_if.o_busy, sr_if.o_done}, 2'b00);
        end
        rst_n = 1'b1;
        step();
        chk("t6 idle after release", {sr_if.o_data_out, sr_if.o_busy, sr_if.o_done}, 18'h0);
        do_load(16'h00F0);
        do_op("t6 log_l4", 1'b1, 2'b00, 5'd4, 1'b0, 16'h0F00, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
